// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory arbiter: parameter defaults,
// FSM state encodings and small index helpers.
package prog_mem_pkg;

  localparam int NUM_CONSUMERS_DEF = 4;
  localparam int ADDR_BITS_DEF     = 8;
  localparam int DATA_BITS_DEF     = 16;

  localparam logic [1:0] ST_IDLE         = 2'b00;
  localparam logic [1:0] ST_READ_WAITING = 2'b01;
  localparam logic [1:0] ST_RELAYING     = 2'b10;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next round-robin position after idx, wrapping back to zero at n.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/prog_mem_arbiter_if.sv
// Fetch-side and program-memory-side bus of the arbiter. The master modport
// is the arbiter itself; the slave modport is the consumers plus memory.
interface prog_mem_arbiter_if
  import prog_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = NUM_CONSUMERS_DEF,
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF
);

  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    input  consumer_read_valid,
    input  consumer_read_address,
    output consumer_read_ready,
    output consumer_read_data,
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    output consumer_read_valid,
    output consumer_read_address,
    input  consumer_read_ready,
    input  consumer_read_data,
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );

endinterface

// File: rtl/prog_mem_arbiter_rr_picker.sv
// Combinational round-robin search: returns the first set request bit at or
// above the pointer, wrapping modulo the number of requesters.
module rr_picker
  import prog_mem_pkg::*;
#(
  parameter int NUM_REQ = NUM_CONSUMERS_DEF,
  parameter int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Walk candidates in priority order starting at the pointer; first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Round-robin arbiter sharing one program memory read port among several
// instruction-fetch consumers. One transaction at a time: grant, wait for
// memory, relay the word until the consumer drops its request.
// Note: the port named reset is active-low and asynchronous.
module prog_mem_arbiter
  import prog_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = NUM_CONSUMERS_DEF,
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  prog_mem_arbiter_if.master bus,
  output logic              busy
);

  localparam int IDX_W = idxWidth(NUM_CONSUMERS);

  logic [1:0]                              r_state;
  logic [IDX_W-1:0]                        r_rrPtr;
  logic [IDX_W-1:0]                        r_grantIdx;
  logic                                    r_memValid;
  logic [ADDR_BITS-1:0]                    r_memAddr;
  logic [NUM_CONSUMERS-1:0]                r_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_data;

  logic             w_found;
  logic [IDX_W-1:0] w_pickIdx;

  rr_picker #(
    .NUM_REQ (NUM_CONSUMERS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (bus.consumer_read_valid),
    .i_ptr   (r_rrPtr),
    .o_found (w_found),
    .o_idx   (w_pickIdx)
  );

  // Transaction FSM: grant in IDLE, hold the memory request until the word
  // arrives, then keep ready up until the granted consumer lets go.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rrPtr    <= '0;
      r_grantIdx <= '0;
      r_memValid <= 1'b0;
      r_memAddr  <= '0;
      r_ready    <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grantIdx <= w_pickIdx;
            r_memAddr  <= bus.consumer_read_address[w_pickIdx];
            r_memValid <= 1'b1;
            r_state    <= ST_READ_WAITING;
          end
        end
        ST_READ_WAITING: begin
          if (bus.mem_read_ready) begin
            r_data[r_grantIdx]  <= bus.mem_read_data;
            r_ready             <= '0;
            r_ready[r_grantIdx] <= 1'b1;
            r_memValid          <= 1'b0;
            r_state             <= ST_RELAYING;
          end
        end
        ST_RELAYING: begin
          if (!bus.consumer_read_valid[r_grantIdx]) begin
            r_ready <= '0;
            r_rrPtr <= IDX_W'(wrapInc(int'(r_grantIdx), NUM_CONSUMERS));
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ready    <= '0;
          r_memValid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.consumer_read_ready = r_ready;
  assign bus.consumer_read_data  = r_data;
  assign bus.mem_read_valid      = r_memValid;
  assign bus.mem_read_address    = r_memAddr;
  assign busy                    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed testbench for prog_mem_arbiter with hand-computed expectations.
module tb_prog_mem_arbiter;

  logic clk;
  logic reset;
  logic busy;

  int errCount   = 0;
  int checkCount = 0;

  prog_mem_arbiter_if busIf ();

  prog_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf),
    .busy  (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the consumer requests and the memory response side.
  task automatic applyStimulus(input logic [3:0] valid, input logic memReady, input logic [15:0] memData);
    busIf.consumer_read_valid = valid;
    busIf.mem_read_ready      = memReady;
    busIf.mem_read_data       = memData;
  endtask

  // Advances one clock; the bench drives and samples 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dataOf(input int idx);
    logic [1:0] sel;
    sel = idx[1:0];
    return 32'(busIf.consumer_read_data[sel]);
  endfunction

  // Pulses the active-low reset and checks the cleared outputs.
  task automatic doReset();
    reset = 1'b0;
    applyStimulus(4'b0000, 1'b0, 16'h0);
    step();
    checkOutput("rst_memvalid", 32'(busIf.mem_read_valid), 32'h0);
    checkOutput("rst_ready", 32'(busIf.consumer_read_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
  endtask

  // Returns the memory word, checks the relay, then lets the consumer go.
  task automatic finishTxn(input int idx, input logic [15:0] word, input logic [3:0] validDuring, input logic [3:0] validAfter);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << idx;
    applyStimulus(validDuring, 1'b1, word);
    step();
    checkOutput("relay_ready", 32'(busIf.consumer_read_ready), 32'(oneHot));
    checkOutput("relay_data", dataOf(idx), 32'(word));
    checkOutput("relay_memvalid", 32'(busIf.mem_read_valid), 32'h0);
    checkOutput("relay_busy", 32'(busy), 32'h1);
    applyStimulus(validAfter, 1'b0, 16'h0);
    step();
    checkOutput("release_ready", 32'(busIf.consumer_read_ready), 32'h0);
    checkOutput("release_busy", 32'(busy), 32'h0);
  endtask

  // Main directed sequence.
  initial begin
    logic [3:0] pending;

    reset = 1'b0;
    applyStimulus(4'b0000, 1'b0, 16'h0);
    busIf.consumer_read_address[0] = 8'h40;
    busIf.consumer_read_address[1] = 8'h41;
    busIf.consumer_read_address[2] = 8'h1A;
    busIf.consumer_read_address[3] = 8'h43;
    repeat (2) step();
    checkOutput("init_memvalid", 32'(busIf.mem_read_valid), 32'h0);
    checkOutput("init_memaddr", 32'(busIf.mem_read_address), 32'h0);
    checkOutput("init_ready", 32'(busIf.consumer_read_ready), 32'h0);
    checkOutput("init_data", 32'(|busIf.consumer_read_data), 32'h0);
    checkOutput("init_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    step();

    $display("[TB] single request from consumer 2");
    applyStimulus(4'b0100, 1'b0, 16'h0);
    step();
    checkOutput("single_memvalid", 32'(busIf.mem_read_valid), 32'h1);
    checkOutput("single_memaddr", 32'(busIf.mem_read_address), 32'h1A);
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_noready", 32'(busIf.consumer_read_ready), 32'h0);
    repeat (2) begin
      step();
      checkOutput("single_wait_valid", 32'(busIf.mem_read_valid), 32'h1);
      checkOutput("single_wait_addr", 32'(busIf.mem_read_address), 32'h1A);
    end
    applyStimulus(4'b0100, 1'b1, 16'hBEEF);
    step();
    checkOutput("single_ready", 32'(busIf.consumer_read_ready), 32'h4);
    checkOutput("single_data", dataOf(2), 32'hBEEF);
    checkOutput("single_memdone", 32'(busIf.mem_read_valid), 32'h0);
    applyStimulus(4'b0100, 1'b0, 16'h0);
    step();
    checkOutput("single_hold", 32'(busIf.consumer_read_ready), 32'h4);
    applyStimulus(4'b0000, 1'b0, 16'h0);
    step();
    checkOutput("single_release", 32'(busIf.consumer_read_ready), 32'h0);
    checkOutput("single_idle", 32'(busy), 32'h0);
    checkOutput("single_keepdata", dataOf(2), 32'hBEEF);

    $display("[TB] wrap-around from pointer 3 with consumers 1 and 3");
    applyStimulus(4'b1010, 1'b0, 16'h0);
    step();
    checkOutput("wrap_first", 32'(busIf.mem_read_address), 32'h43);
    finishTxn(3, 16'h3333, 4'b1010, 4'b0010);
    step();
    checkOutput("wrap_second", 32'(busIf.mem_read_address), 32'h41);
    finishTxn(1, 16'h1111, 4'b0010, 4'b0000);
    checkOutput("wrap_keepdata2", dataOf(2), 32'hBEEF);

    $display("[TB] all four consumers from reset");
    doReset();
    for (int k = 0; k < 4; k++) busIf.consumer_read_address[k] = 8'(8'h10 + k);
    pending = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(pending, 1'b0, 16'h0);
      step();
      checkOutput("all_grant", 32'(busIf.mem_read_address), 32'(8'h10 + k));
      checkOutput("all_noready", 32'(busIf.consumer_read_ready), 32'h0);
      pending[k] = 1'b0;
      finishTxn(k, 16'(16'hA000 + k), pending | (4'b0001 << k), pending);
    end

    $display("[TB] fairness between consumers 0 and 1");
    doReset();
    busIf.consumer_read_address[0] = 8'h20;
    busIf.consumer_read_address[1] = 8'h21;
    applyStimulus(4'b0001, 1'b0, 16'h0);
    step();
    checkOutput("fair_grant0", 32'(busIf.mem_read_address), 32'h20);
    applyStimulus(4'b0011, 1'b0, 16'h0);
    step();
    checkOutput("fair_nopreempt", 32'(busIf.mem_read_address), 32'h20);
    finishTxn(0, 16'h5A5A, 4'b0011, 4'b0010);
    applyStimulus(4'b0011, 1'b0, 16'h0);
    step();
    checkOutput("fair_grant1", 32'(busIf.mem_read_address), 32'h21);
    finishTxn(1, 16'h6B6B, 4'b0011, 4'b0001);
    step();
    checkOutput("fair_back0", 32'(busIf.mem_read_address), 32'h20);
    finishTxn(0, 16'h7C7C, 4'b0001, 4'b0000);

    $display("[TB] abandoned request from consumer 1");
    doReset();
    busIf.consumer_read_address[1] = 8'h31;
    busIf.consumer_read_address[3] = 8'h33;
    applyStimulus(4'b0010, 1'b0, 16'h0);
    step();
    checkOutput("aband_grant", 32'(busIf.mem_read_address), 32'h31);
    applyStimulus(4'b0000, 1'b0, 16'h0);
    step();
    checkOutput("aband_stillvalid", 32'(busIf.mem_read_valid), 32'h1);
    checkOutput("aband_busy", 32'(busy), 32'h1);
    applyStimulus(4'b0000, 1'b1, 16'h1234);
    step();
    checkOutput("aband_ready", 32'(busIf.consumer_read_ready), 32'h2);
    checkOutput("aband_data", dataOf(1), 32'h1234);
    applyStimulus(4'b0000, 1'b0, 16'h0);
    step();
    checkOutput("aband_readyoff", 32'(busIf.consumer_read_ready), 32'h0);
    checkOutput("aband_idle", 32'(busy), 32'h0);
    step();
    checkOutput("aband_nogrant", 32'(busIf.mem_read_valid), 32'h0);

    $display("[TB] reset during READ_WAITING");
    applyStimulus(4'b1010, 1'b0, 16'h0);
    step();
    checkOutput("rstmid_grant3", 32'(busIf.mem_read_address), 32'h33);
    step();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstmid_memvalid", 32'(busIf.mem_read_valid), 32'h0);
    checkOutput("rstmid_memaddr", 32'(busIf.mem_read_address), 32'h0);
    checkOutput("rstmid_busy", 32'(busy), 32'h0);
    checkOutput("rstmid_data", 32'(|busIf.consumer_read_data), 32'h0);
    applyStimulus(4'b1010, 1'b1, 16'hDEAD);
    step();
    checkOutput("rstmid_noready", 32'(busIf.consumer_read_ready), 32'h0);
    reset = 1'b1;
    applyStimulus(4'b1010, 1'b0, 16'h0);
    step();
    checkOutput("rstmid_regrant", 32'(busIf.mem_read_address), 32'h31);
    checkOutput("rstmid_regrant_noready", 32'(busIf.consumer_read_ready), 32'h0);
    finishTxn(1, 16'h4321, 4'b1010, 4'b1000);
    step();
    checkOutput("rstmid_next3", 32'(busIf.mem_read_address), 32'h33);
    finishTxn(3, 16'h8765, 4'b1000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
